// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches through a req/ack handshake
// and computes the next PC from the decoder's selects when execution completes.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  nPC_sel,
  input  logic [1:0]  j_sel,
  input  logic        zero,
  input  logic [31:0] ra_data,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic        pc_ld, instr_ld, err_set;
  logic [31:0] next_pc, br_tgt;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign br_tgt    = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};

  // Next-PC selection from the decoder selects, zero flag and GPR[rs]
  always_comb begin
    next_pc = pc_plus4;
    case (nPC_sel)
      2'b01: begin
        if (j_sel == 2'b01)      next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
        else if (j_sel == 2'b10) next_pc = ra_data;
      end
      2'b10: if (zero)  next_pc = br_tgt;
      2'b11: if (!zero) next_pc = br_tgt;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    instr_ld  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_ld  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (next_pc[1:0] != 2'b00) begin
            err_set   = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_ld     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/valid flags are registered from the next state so they track the state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      imem_req    <= (state_nxt == REQ);
      instr_valid <= (state_nxt == EXEC);
      if (pc_ld)    pc          <= next_pc;
      if (instr_ld) instruction <= imem_rdata;
      if (err_set)  fetch_err   <= 1'b1;
    end
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS core. Holds the PC, fetches one instruction per step from instruction memory through a req/ack handshake, and presents it to the decoder. When the datapath reports the instruction complete, it computes the next PC from the decoder's `nPC_sel`/`j_sel`, the ALU `zero` flag and GPR[rs]. It sits directly upstream of the controller/datapath and consumes the controller's next-PC selects.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `nPC_sel`  in  2  next-PC select:
  - 00: sequential.
  - 01: jump.
  - 10: BEQ.
  - 11: BNE.
- `j_sel`  in  2  jump kind, used when nPC_sel=01:
  - 01: J (absolute target).
  - 10: JR (register target).
  - 00/11: sequential.
- `zero`  in  1  ALU zero flag for the current instruction.
- `ra_data`  in  32  GPR[rs] read data, the JR target.
- `exec_done`  in  1  current instruction committed; advance the PC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `instruction`  out  32  latched instruction to the decoder.
- `instr_valid`  out  1  `instruction` is valid and stable.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `fetch_err`  out  1  sticky flag for a misaligned next PC.

## Operation
- States:
  - IDLE: no request.
  - REQ: `imem_req`=1.
  - EXEC: `instr_valid`=1.
  - HALT: fault.
- Reset values: state=IDLE, `pc`=RESET_PC, `instruction`=0, `instr_valid`=0, `imem_req`=0, `fetch_err`=0.
- IDLE → REQ unconditionally on the next cycle.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until acknowledged.
  - On `imem_ack`=1: `instruction` ← `imem_rdata`, state → EXEC.
- EXEC:
  - `instruction` is held stable.
  - On `exec_done`=1: `pc` ← next_pc, state → REQ.
  - If next_pc[1:0]≠0: `pc` is unchanged, `fetch_err` ← 1, state → HALT.
- HALT: no request, `instr_valid`=0. Only `rst` exits this state; reset also clears `fetch_err`.
- next_pc is evaluated combinationally from inputs sampled in the `exec_done` cycle:
  - nPC_sel=00: `pc_plus4`.
  - nPC_sel=01, j_sel=01: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - nPC_sel=01, j_sel=10: `ra_data`.
  - nPC_sel=01, other j_sel: `pc_plus4`.
  - nPC_sel=10: `zero` ? br_tgt : `pc_plus4`.
  - nPC_sel=11: !`zero` ? br_tgt : `pc_plus4`.
  - br_tgt = `pc_plus4` + (sign_extend(instruction[15:0]) << 2).
- Arithmetic is 32-bit modular: 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag raised.
- There is no branch delay slot.
- `imem_ack` is ignored outside REQ. `exec_done` is ignored outside EXEC.

## Timing
- Sequence from reset release:
  - Cycle 0: IDLE.
  - Cycle 1: REQ.
  - With `imem_ack` in cycle 1, `instr_valid` rises in cycle 2.
- Fetch latency: `instr_valid` rises in the cycle after the ack. Each extra wait cycle before the ack adds one cycle.
- `exec_done` may be asserted in the first `instr_valid` cycle. In that case `instr_valid` falls and `imem_req` rises in the next cycle.
- Minimum throughput: 2 cycles per instruction.
- `pc` updates on the edge that ends the `exec_done` cycle. `pc_plus4` follows combinationally.
- `rst` has priority over all events:
  - A reset during REQ abandons the request.
  - An ack arriving after the reset is ignored, because the unit is in IDLE.
- `imem_addr` must not change while `imem_req`=1 and no ack has been received.

## Test plan
- Reset, then ack in the same cycle as the request:
  - `imem_req`=1 at cycle 1 with `imem_addr`=0x3000.
  - `instr_valid`=1 at cycle 2.
  - `exec_done` with nPC_sel=00 → next `imem_addr`=0x3004.
- Ack delayed 3 cycles:
  - `imem_req` is held for 4 cycles with `imem_addr` stable at 0x3004.
  - `instr_valid` stays 0 until the cycle after the ack.
  - `instruction` equals the acked `imem_rdata`.
- BEQ at `pc`=0x3010 with imm16=0xFFFC:
  - `zero`=1 → next PC 0x3004.
  - `zero`=0 → next PC 0x3014.
  - BNE with the same operands gives the inverse results.
- J at `pc`=0x3000 with instruction 0x0800_0C10 → next PC 0x0000_3040.
- JR:
  - `ra_data`=0x3100 → next PC 0x3100.
  - `ra_data`=0x3102 → `fetch_err`=1, HALT, `pc` stays, no further `imem_req` until `rst`.
- Reset mid-request and wrap-around:
  - `rst` during REQ, then a late `imem_ack` → ack ignored, fetch restarts at 0x3000.
  - JR to 0xFFFF_FFFC, then sequential → next `imem_addr`=0x0000_0000.
